mux_select_ctrl: RTL and testbench

//   Generates the registered select line `s` for the downstream 2:1 mux from raw board inputs.

---
 rtl/mux_select_ctrl.sv | 156 +++++++++++++++
 tb/tb_mux_select_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// mux_select_ctrl
//   Produces the registered select line `s` for a downstream 2:1 mux from a
//   raw push-button and a raw slide switch. Both inputs are synchronised
//   (2-FF) and debounced. The select is driven according to `mode`:
//     00 switch level, 01 button toggle, 10 auto-alternate, 11 hold.
//   A one-cycle strobe marks every change of `s`.
//
// Ports
//   clk          in  1  system clock, rising edge
//   rst          in  1  asynchronous active-high reset
//   btn_in       in  1  raw push-button (asynchronous, bouncy)
//   sw_in        in  1  raw slide switch (asynchronous, bouncy)
//   mode         in  2  select mode, sampled every edge
//   s            out 1  registered mux select (0 = x, 1 = y)
//   sel_changed  out 1  one-cycle pulse coincident with each new value of s
//   btn_db       out 1  debounced button level
// -----------------------------------------------------------------------------
module mux_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_PERIOD     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       sw_in,
    input  logic [1:0] mode,
    output logic       s,
    output logic       sel_changed,
    output logic       btn_db
);

    // A debounce length of 1 would give a zero-width counter; keep at least one bit.
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = $clog2(AUTO_PERIOD);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  AUTO_LAST = TW'(AUTO_PERIOD - 1);

    localparam logic [1:0] MODE_SW   = 2'b00;
    localparam logic [1:0] MODE_BTN  = 2'b01;
    localparam logic [1:0] MODE_AUTO = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic           btn_meta_r, btn_sync_r;
    logic           sw_meta_r,  sw_sync_r;
    logic           btn_stable_r, sw_stable_r;
    logic [DBW-1:0] btn_cnt_r, sw_cnt_r;
    logic           btn_prev_r;
    logic [TW-1:0]  timer_r;

    logic           btn_stable_s, sw_stable_s;
    logic [DBW-1:0] btn_cnt_s, sw_cnt_s;
    logic           btn_rise_s;
    logic [TW-1:0]  timer_s;
    logic           s_next_s;

    // Debounce next-state: accept the synced level only after it has differed
    // from the stable level for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        btn_stable_s = btn_stable_r;
        btn_cnt_s    = {DBW{1'b0}};
        if (btn_sync_r != btn_stable_r) begin
            if (btn_cnt_r == DB_LAST) begin
                btn_stable_s = btn_sync_r;
                btn_cnt_s    = {DBW{1'b0}};
            end else begin
                btn_cnt_s    = btn_cnt_r + DBW'(1);
            end
        end else begin
            btn_cnt_s = {DBW{1'b0}};
        end

        sw_stable_s = sw_stable_r;
        sw_cnt_s    = {DBW{1'b0}};
        if (sw_sync_r != sw_stable_r) begin
            if (sw_cnt_r == DB_LAST) begin
                sw_stable_s = sw_sync_r;
                sw_cnt_s    = {DBW{1'b0}};
            end else begin
                sw_cnt_s    = sw_cnt_r + DBW'(1);
            end
        end else begin
            sw_cnt_s = {DBW{1'b0}};
        end
    end

    // Select next-state by mode; the auto timer only runs while in auto mode,
    // so entering auto always yields the first toggle AUTO_PERIOD edges later.
    always_comb begin
        btn_rise_s = btn_stable_r & ~btn_prev_r;
        s_next_s   = s;
        timer_s    = {TW{1'b0}};
        case (mode)
            MODE_SW: begin
                s_next_s = sw_stable_r;
            end
            MODE_BTN: begin
                if (btn_rise_s) begin
                    s_next_s = ~s;
                end else begin
                    s_next_s = s;
                end
            end
            MODE_AUTO: begin
                if (timer_r == AUTO_LAST) begin
                    s_next_s = ~s;
                    timer_s  = {TW{1'b0}};
                end else begin
                    s_next_s = s;
                    timer_s  = timer_r + TW'(1);
                end
            end
            MODE_HOLD: begin
                s_next_s = s;
            end
            default: begin
                s_next_s = s;
            end
        endcase
    end

    // All state: synchronisers, debouncers, edge register, auto timer, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_r   <= 1'b0;
            btn_sync_r   <= 1'b0;
            sw_meta_r    <= 1'b0;
            sw_sync_r    <= 1'b0;
            btn_stable_r <= 1'b0;
            sw_stable_r  <= 1'b0;
            btn_cnt_r    <= {DBW{1'b0}};
            sw_cnt_r     <= {DBW{1'b0}};
            btn_prev_r   <= 1'b0;
            timer_r      <= {TW{1'b0}};
            s            <= 1'b0;
            sel_changed  <= 1'b0;
        end else begin
            btn_meta_r   <= btn_in;
            btn_sync_r   <= btn_meta_r;
            sw_meta_r    <= sw_in;
            sw_sync_r    <= sw_meta_r;
            btn_stable_r <= btn_stable_s;
            sw_stable_r  <= sw_stable_s;
            btn_cnt_r    <= btn_cnt_s;
            sw_cnt_r     <= sw_cnt_s;
            btn_prev_r   <= btn_stable_r;
            timer_r      <= timer_s;
            s            <= s_next_s;
            sel_changed  <= (s_next_s != s);
        end
    end

    assign btn_db = btn_stable_r;

endmodule

// File: tb/tb_mux_select_ctrl.sv
module tb_mux_select_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       sw_in;
    logic [1:0] mode;
    logic       s;
    logic       sel_changed;
    logic       btn_db;

    int total_cnt;
    int bad_cnt;
    int pulses;

    mux_select_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .sw_in      (sw_in),
        .mode       (mode),
        .s          (s),
        .sel_changed(sel_changed),
        .btn_db     (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n edges, counting sel_changed pulses seen.
    task automatic tick_count(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sel_changed) cnt++;
        end
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst    = 1'b1;
        btn_in = 1'b0;
        sw_in  = 1'b0;
        mode   = 2'b00;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_val("rst_s", {31'd0, s}, 32'd0);
        check_val("rst_sc", {31'd0, sel_changed}, 32'd0);
        check_val("rst_btn_db", {31'd0, btn_db}, 32'd0);

        // Switch-level mode: switch change reaches s on edge 7.
        sw_in = 1'b1;
        tick(6);
        check_val("sw_rise_e6_s", {31'd0, s}, 32'd0);
        tick(1);
        check_val("sw_rise_e7_s", {31'd0, s}, 32'd1);
        check_val("sw_rise_e7_sc", {31'd0, sel_changed}, 32'd1);
        tick(1);
        check_val("sw_rise_e8_sc", {31'd0, sel_changed}, 32'd0);
        check_val("sw_rise_e8_s", {31'd0, s}, 32'd1);
        sw_in = 1'b0;
        tick(6);
        check_val("sw_fall_e6_s", {31'd0, s}, 32'd1);
        tick(1);
        check_val("sw_fall_e7_s", {31'd0, s}, 32'd0);
        check_val("sw_fall_e7_sc", {31'd0, sel_changed}, 32'd1);
        tick(1);
        check_val("sw_fall_e8_sc", {31'd0, sel_changed}, 32'd0);

        // Asynchronous reset between edges with s=1.
        sw_in = 1'b1;
        tick(7);
        check_val("pre_rst_s", {31'd0, s}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_s", {31'd0, s}, 32'd0);
        check_val("async_rst_sc", {31'd0, sel_changed}, 32'd0);
        check_val("async_rst_btn_db", {31'd0, btn_db}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_val("hold_rst_s", {31'd0, s}, 32'd0);
        end
        sw_in = 1'b0;
        rst   = 1'b0;
        tick(8);
        check_val("post_rst_s", {31'd0, s}, 32'd0);

        // Button-toggle mode: 3-cycle press is a bounce and is rejected.
        mode   = 2'b01;
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_val("short_btn_db", {31'd0, btn_db}, 32'd0);
            check_val("short_btn_s", {31'd0, s}, 32'd0);
        end
        // Long press toggles once at edge 7.
        btn_in = 1'b1;
        tick(6);
        check_val("press_e6_btn_db", {31'd0, btn_db}, 32'd1);
        check_val("press_e6_s", {31'd0, s}, 32'd0);
        tick(1);
        check_val("press_e7_s", {31'd0, s}, 32'd1);
        check_val("press_e7_sc", {31'd0, sel_changed}, 32'd1);
        tick(1);
        check_val("press_e8_sc", {31'd0, sel_changed}, 32'd0);
        tick(2);
        btn_in = 1'b0;
        tick_count(8, pulses);
        check_val("release_pulses", pulses, 32'd0);
        check_val("release_s", {31'd0, s}, 32'd1);
        check_val("release_btn_db", {31'd0, btn_db}, 32'd0);
        // Second press toggles back; a 2-cycle bounce during the hold is ignored.
        btn_in = 1'b1;
        tick(7);
        check_val("press2_s", {31'd0, s}, 32'd0);
        check_val("press2_sc", {31'd0, sel_changed}, 32'd1);
        tick(3);
        btn_in = 1'b0;
        tick(2);
        btn_in = 1'b1;
        tick_count(10, pulses);
        check_val("bounce_pulses", pulses, 32'd0);
        check_val("bounce_s", {31'd0, s}, 32'd0);
        check_val("bounce_btn_db", {31'd0, btn_db}, 32'd1);
        btn_in = 1'b0;
        tick(8);

        // Auto mode: toggle every 5 edges starting from s=0.
        mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick_count(4, pulses);
            check_val("auto_gap_pulses", pulses, 32'd0);
            tick(1);
            check_val("auto_toggle_s", {31'd0, s}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_val("auto_toggle_sc", {31'd0, sel_changed}, 32'd1);
        end
        // Hold mode freezes s.
        mode = 2'b11;
        tick_count(20, pulses);
        check_val("hold_pulses", pulses, 32'd0);
        check_val("hold_s", {31'd0, s}, 32'd1);

        // Reset with the auto timer mid-count, then first toggle after 5 edges.
        mode = 2'b10;
        tick(3);
        check_val("auto_pre_rst_s", {31'd0, s}, 32'd1);
        rst = 1'b1;
        tick(2);
        check_val("auto_rst_s", {31'd0, s}, 32'd0);
        rst = 1'b0;
        tick_count(4, pulses);
        check_val("auto_restart_gap", pulses, 32'd0);
        check_val("auto_restart_e4_s", {31'd0, s}, 32'd0);
        tick(1);
        check_val("auto_restart_e5_s", {31'd0, s}, 32'd1);
        check_val("auto_restart_e5_sc", {31'd0, sel_changed}, 32'd1);

        // Button mode with s=1, switch debounced to 1 meanwhile; then back to switch mode.
        mode  = 2'b01;
        sw_in = 1'b1;
        tick_count(8, pulses);
        check_val("btn_mode_sw_pulses", pulses, 32'd0);
        check_val("btn_mode_s", {31'd0, s}, 32'd1);
        mode = 2'b00;
        tick(1);
        check_val("to_sw_same_s", {31'd0, s}, 32'd1);
        check_val("to_sw_same_sc", {31'd0, sel_changed}, 32'd0);
        sw_in = 1'b0;
        tick_count(6, pulses);
        check_val("to_sw_gap_pulses", pulses, 32'd0);
        tick(1);
        check_val("to_sw_e7_s", {31'd0, s}, 32'd0);
        check_val("to_sw_e7_sc", {31'd0, sel_changed}, 32'd1);
        tick(1);
        check_val("to_sw_e8_sc", {31'd0, sel_changed}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
